// File: rtl/vpu_narrow_pkg.sv
// Shared definitions for the narrowing shift/clip unit: widths, op and
// rounding-mode encodings, and the stage-1 payload carried down the pipe.
package vpu_narrow_pkg;

    localparam int unsigned SEW  = 32;
    localparam int unsigned WIDE = 64;
    localparam int unsigned SHW  = 6;

    typedef enum logic [1:0] {
        OP_NSRL   = 2'b00,
        OP_NSRA   = 2'b01,
        OP_NCLIPU = 2'b10,
        OP_NCLIP  = 2'b11
    } narrow_op_e;

    typedef enum logic [1:0] {
        RM_RNU = 2'b00,
        RM_RNE = 2'b01,
        RM_RDN = 2'b10,
        RM_ROD = 2'b11
    } narrow_vxrm_e;

    typedef struct packed {
        logic [WIDE-1:0] sh;
        logic            inc;
        narrow_op_e      op;
    } s1_payload_t;

    function automatic logic op_is_arith(input narrow_op_e op);
        return (op == OP_NSRA) || (op == OP_NCLIP);
    endfunction

    function automatic logic op_is_clip(input narrow_op_e op);
        return (op == OP_NCLIPU) || (op == OP_NCLIP);
    endfunction

endpackage

// File: rtl/narrow_round_inc.sv
// Fixed-point rounding increment for a right shift of v by d under vxrm.
// Purely combinational so the scaling-shift unit can share it.
module narrow_round_inc
    import vpu_narrow_pkg::*;
(
    input  logic [WIDE-1:0] v,
    input  logic [SHW-1:0]  d,
    input  logic [1:0]      vxrm,
    output logic            r
);

    logic [WIDE-1:0] below_mask;
    logic            bit_lsb;
    logic            bit_half;
    logic            sticky_below;

    always_comb begin
        r            = 1'b0;
        below_mask   = '0;
        bit_lsb      = 1'b0;
        bit_half     = 1'b0;
        sticky_below = 1'b0;
        if (d != '0) begin
            bit_lsb      = v[d];
            bit_half     = v[d - SHW'(1)];
            // Covers bits [d-2:0]; empty (all zero) when d == 1.
            below_mask   = (WIDE'(1) << (d - SHW'(1))) - WIDE'(1);
            sticky_below = |(v & below_mask);
            case (narrow_vxrm_e'(vxrm))
                RM_RNU: r = bit_half;
                RM_RNE: r = bit_half & (bit_lsb | sticky_below);
                RM_RDN: r = 1'b0;
                RM_ROD: r = ~bit_lsb & (bit_half | sticky_below);
                default: r = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/narrow_clip_64.sv
// Two-stage narrowing shift / clip: stage 1 shifts and computes the rounding
// increment, stage 2 adds, saturates and narrows 64 -> 32 bits.
module narrow_clip_64
    import vpu_narrow_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDE-1:0]     in_data,
    input  logic [SHW-1:0]      in_shamt,
    input  logic [1:0]          in_op,
    input  logic [1:0]          in_vxrm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SEW-1:0]      out_data,
    output logic                out_sat,
    output logic                vxsat,
    input  logic                vxsat_clr
);

    logic                   s1_valid_q, s1_valid_d;
    s1_payload_t            s1_q, s1_d;
    logic                   out_valid_q, out_valid_d;
    logic [SEW-1:0]         out_data_q, out_data_d;
    logic                   out_sat_q, out_sat_d;
    logic                   vxsat_q, vxsat_d;

    narrow_op_e             op_in;
    logic signed [WIDE-1:0] sra_val;
    logic [WIDE-1:0]        srl_val;
    logic                   rinc;
    s1_payload_t            s1_in;

    logic                   s1_advance;
    logic                   in_fire;

    logic                   t_ext;
    logic [WIDE:0]          t_sum;
    logic [SEW-1:0]         s2_res;
    logic                   s2_sat;

    narrow_round_inc u_round (
        .v    (in_data),
        .d    (in_shamt),
        .vxrm (in_vxrm),
        .r    (rinc)
    );

    // Stage 1: shift selected by op; increment only applies to the clip ops.
    always_comb begin
        op_in    = narrow_op_e'(in_op);
        sra_val  = $signed(in_data) >>> in_shamt;
        srl_val  = in_data >> in_shamt;
        s1_in    = '0;
        s1_in.op = op_in;
        s1_in.sh = op_is_arith(op_in) ? sra_val : srl_val;
        s1_in.inc = rinc & op_is_clip(op_in);
    end

    // Stage 2: 65-bit add, then saturate to the 32-bit range of the op.
    always_comb begin
        t_ext  = (s1_q.op == OP_NCLIP) ? s1_q.sh[WIDE-1] : 1'b0;
        t_sum  = {t_ext, s1_q.sh} + {{WIDE{1'b0}}, s1_q.inc};
        s2_res = s1_q.sh[SEW-1:0];
        s2_sat = 1'b0;
        case (s1_q.op)
            OP_NCLIPU: begin
                if (t_sum[WIDE:SEW] != '0) begin
                    s2_res = '1;
                    s2_sat = 1'b1;
                end else begin
                    s2_res = t_sum[SEW-1:0];
                end
            end
            OP_NCLIP: begin
                // In range iff bits [64:31] are all copies of the sign.
                if ((&t_sum[WIDE:SEW-1]) || !(|t_sum[WIDE:SEW-1])) begin
                    s2_res = t_sum[SEW-1:0];
                end else begin
                    s2_res = t_sum[WIDE] ? {1'b1, {(SEW-1){1'b0}}}
                                         : {1'b0, {(SEW-1){1'b1}}};
                    s2_sat = 1'b1;
                end
            end
            default: begin
                s2_res = s1_q.sh[SEW-1:0];
                s2_sat = 1'b0;
            end
        endcase
    end

    always_comb begin
        s1_advance  = s1_valid_q & (~out_valid_q | out_ready);
        in_ready    = ~s1_valid_q | s1_advance;
        in_fire     = in_valid & in_ready;

        s1_valid_d  = in_fire | (s1_valid_q & ~s1_advance);
        s1_d        = in_fire ? s1_in : s1_q;

        out_valid_d = s1_advance | (out_valid_q & ~out_ready);
        out_data_d  = s1_advance ? s2_res : out_data_q;
        out_sat_d   = s1_advance ? s2_sat : out_sat_q;

        // A saturating handshake overrides a simultaneous clear.
        vxsat_d     = (out_valid_q & out_ready & out_sat_q) | (vxsat_q & ~vxsat_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            vxsat_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            vxsat_q     <= vxsat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign vxsat     = vxsat_q;

endmodule

// File: tb/tb_narrow_clip_64.sv
// Directed bench for narrow_clip_64 with hand-computed expected values.
module tb_narrow_clip_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    logic [1:0]  in_op;
    logic [1:0]  in_vxrm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        vxsat;
    logic        vxsat_clr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  rm;
        logic [5:0]  d;
        logic [63:0] din;
        logic [31:0] dout;
        logic        sat;
    } vec_t;

    vec_t vecs[13];
    vec_t bp[4];

    narrow_clip_64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_vxrm   (in_vxrm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .vxsat     (vxsat),
        .vxsat_clr (vxsat_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic present(input vec_t v);
        in_valid = 1'b1;
        in_op    = v.op;
        in_vxrm  = v.rm;
        in_shamt = v.d;
        in_data  = v.din;
    endtask

    // One element through an empty pipe with out_ready high; vxsat cleared on entry.
    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        present(v);
        vxsat_clr = 1'b1;
        check({name, ".rdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        vxsat_clr = 1'b0;
        check({name, ".lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({name, ".vld"}, 64'(out_valid), 64'd1);
        check({name, ".data"}, 64'(out_data), 64'(v.dout));
        check({name, ".sat"}, 64'(out_sat), 64'(v.sat));
        @(negedge clk);
        check({name, ".drain"}, 64'(out_valid), 64'd0);
        check({name, ".vxsat"}, 64'(vxsat), 64'(v.sat));
    endtask

    initial begin
        int idx;
        int nout;
        logic seen;

        vecs[0]  = '{2'b11, 2'b00, 6'd4,  64'h0000_0000_0000_0018, 32'h0000_0002, 1'b0};
        vecs[1]  = '{2'b11, 2'b01, 6'd4,  64'h0000_0000_0000_0028, 32'h0000_0002, 1'b0};
        vecs[2]  = '{2'b11, 2'b01, 6'd4,  64'h0000_0000_0000_0038, 32'h0000_0004, 1'b0};
        vecs[3]  = '{2'b11, 2'b11, 6'd4,  64'h0000_0000_0000_0028, 32'h0000_0003, 1'b0};
        vecs[4]  = '{2'b11, 2'b10, 6'd4,  64'hFFFF_FFFF_FFFF_FFE8, 32'hFFFF_FFFE, 1'b0};
        vecs[5]  = '{2'b11, 2'b00, 6'd0,  64'h0000_0001_0000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[6]  = '{2'b10, 2'b00, 6'd32, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{2'b01, 2'b00, 6'd16, 64'hFFFF_FFFF_8000_0000, 32'hFFFF_8000, 1'b0};
        vecs[8]  = '{2'b00, 2'b00, 6'd16, 64'hFFFF_FFFF_8000_0000, 32'hFFFF_8000, 1'b0};
        vecs[9]  = '{2'b11, 2'b00, 6'd0,  64'h8000_0000_0000_0000, 32'h8000_0000, 1'b1};
        vecs[10] = '{2'b10, 2'b01, 6'd8,  64'h0000_0000_1234_5680, 32'h0012_3456, 1'b0};
        vecs[11] = '{2'b00, 2'b00, 6'd4,  64'h0000_0000_0000_0018, 32'h0000_0001, 1'b0};
        vecs[12] = '{2'b11, 2'b00, 6'd63, 64'h4000_0000_0000_0000, 32'h0000_0001, 1'b0};

        bp[0] = '{2'b11, 2'b00, 6'd4, 64'h0000_0000_0000_0018, 32'h0000_0002, 1'b0};
        bp[1] = '{2'b00, 2'b00, 6'd8, 64'h0000_00AB_CDEF_0100, 32'hABCD_EF01, 1'b0};
        bp[2] = '{2'b10, 2'b10, 6'd0, 64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        bp[3] = '{2'b01, 2'b01, 6'd1, 64'hFFFF_FFFF_0000_0002, 32'h8000_0001, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_vxrm   = '0;
        out_ready = 1'b1;
        vxsat_clr = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_data", 64'(out_data), 64'd0);
        check("rst.out_sat", 64'(out_sat), 64'd0);
        check("rst.vxsat", 64'(vxsat), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: four mixed-op elements with the consumer stalled
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (idx < 4) present(bp[idx]);
            else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) idx++;
        end
        check("bp.accepted", 64'(idx), 64'd2);
        check("bp.in_ready", 64'(in_ready), 64'd0);
        check("bp.hold_vld", 64'(out_valid), 64'd1);
        check("bp.hold_data", 64'(out_data), 64'(bp[0].dout));
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        nout = 0;
        for (int c = 0; c < 20 && nout < 4; c++) begin
            if (out_valid) begin
                check($sformatf("bp.data%0d", nout), 64'(out_data), 64'(bp[nout].dout));
                check($sformatf("bp.sat%0d", nout), 64'(out_sat), 64'(bp[nout].sat));
                nout++;
            end
            if (idx < 4) begin
                present(bp[idx]);
                #1;
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp.count", 64'(nout), 64'd4);
        @(negedge clk);
        @(negedge clk);

        // Clear colliding with a saturating handshake: set wins
        @(negedge clk);
        present(vecs[5]);
        vxsat_clr = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        vxsat_clr = 1'b0;
        @(negedge clk);
        check("clr.vld", 64'(out_valid), 64'd1);
        vxsat_clr = 1'b1;
        @(negedge clk);
        check("clr.set_wins", 64'(vxsat), 64'd1);
        @(negedge clk);
        check("clr.cleared", 64'(vxsat), 64'd0);
        vxsat_clr = 1'b0;

        // Reset with two elements in flight
        out_ready = 1'b0;
        @(negedge clk);
        present(vecs[0]);
        @(negedge clk);
        present(vecs[3]);
        @(negedge clk);
        in_valid = 1'b0;
        check("rstf.pre_vld", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstf.vld", 64'(out_valid), 64'd0);
        check("rstf.data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rstf.in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("rstf.no_stale", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
